alu_accumulator: RTL and testbench

//   Execute stage downstream of the instruction sequencer. On each one-cycle Exec strobe it decodes IR and combines the

---
 rtl/alu_accumulator.sv | 197 +++++++++++++++++++
 tb/tb_alu_accumulator.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : alu_accumulator
//  Description : Accumulator execute stage. Single-cycle ALU ops on AR with an
//                immediate/memory operand, plus an iterative shift-add MUL.
//                Opcode layout: IR[7:6] group, IR[5:3] op, IR[2] operand-2
//                select (1 = MBR). LOAD_I = 8'h00, LOAD_X = 8'h04.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_accumulator #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  Exec,
    input  logic [7:0]            IR,
    input  logic [DATA_WIDTH-1:0] IBR,
    input  logic [DATA_WIDTH-1:0] MBR,
    output logic [DATA_WIDTH-1:0] AR,
    output logic [DATA_WIDTH-1:0] HR,
    output logic [3:0]            Flags,
    output logic                  busy
);

    localparam int             c_flag_ov    = 3;
    localparam int             c_flag_neg   = 2;
    localparam int             c_flag_carry = 1;
    localparam int             c_flag_zero  = 0;
    localparam int             c_oper2_bit  = 2;
    localparam logic           c_oper2_x    = 1'b1;
    localparam logic [7:0]     c_load_i     = 8'h00;
    localparam logic [7:0]     c_load_x     = 8'h04;
    localparam int             c_msb        = DATA_WIDTH - 1;
    localparam int             c_cnt_w      = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DATA_WIDTH - 1);
    localparam logic [0:0]     c_st_idle    = 1'b0;
    localparam logic [0:0]     c_st_mul     = 1'b1;

    logic [0:0]              r_state;
    logic [0:0]              w_state_nxt;
    logic [DATA_WIDTH-1:0]   r_ar;
    logic [DATA_WIDTH-1:0]   r_hr;
    logic [3:0]              r_flags;
    logic [2*DATA_WIDTH-1:0] r_mcand;
    logic [DATA_WIDTH-1:0]   r_mplier;
    logic [2*DATA_WIDTH-1:0] r_acc;
    logic [c_cnt_w-1:0]      r_cnt;

    logic                    w_exec;
    logic [DATA_WIDTH-1:0]   w_op2;
    logic [DATA_WIDTH:0]     w_cin_ext;
    logic [DATA_WIDTH:0]     w_sum;
    logic [DATA_WIDTH-1:0]   w_res;
    logic [3:0]              w_flags;
    logic                    w_c;
    logic                    w_v;
    logic                    w_sub;
    logic                    w_wr_ar;
    logic                    w_wr_flags;
    logic                    w_start_mul;
    logic [2*DATA_WIDTH-1:0] w_acc_nxt;
    logic                    w_mul_last;
    logic [DATA_WIDTH-1:0]   w_prod_lo;
    logic [DATA_WIDTH-1:0]   w_prod_hi;
    logic [3:0]              w_mul_flags;

    // Single-cycle decode; only acted upon while the FSM is idle.
    always_comb begin
        w_exec      = Exec && (r_state == c_st_idle);
        w_op2       = (IR[c_oper2_bit] == c_oper2_x) ? MBR : IBR;
        w_cin_ext   = {{DATA_WIDTH{1'b0}}, r_flags[c_flag_carry]};
        w_sum       = '0;
        w_res       = r_ar;
        w_flags     = r_flags;
        w_c         = 1'b0;
        w_v         = 1'b0;
        w_sub       = 1'b0;
        w_wr_ar     = 1'b0;
        w_wr_flags  = 1'b0;
        w_start_mul = 1'b0;

        case (IR[7:6])
            2'b00: begin
                if ((IR == c_load_i) || (IR == c_load_x)) begin
                    w_wr_ar = 1'b1;
                    w_res   = w_op2;
                end
            end
            2'b01: begin
                case (IR[5:3])
                    3'b000:        w_sum = {1'b0, r_ar} + {1'b0, w_op2};
                    3'b010:        w_sum = {1'b0, r_ar} + {1'b0, w_op2} + w_cin_ext;
                    3'b001, 3'b100: w_sum = {1'b0, r_ar} - {1'b0, w_op2};
                    3'b011:        w_sum = {1'b0, r_ar} - {1'b0, w_op2} - w_cin_ext;
                    default:       w_sum = '0;
                endcase
                w_sub       = (IR[5:3] == 3'b001) || (IR[5:3] == 3'b011) || (IR[5:3] == 3'b100);
                w_res       = w_sum[DATA_WIDTH-1:0];
                // Bit DATA_WIDTH is carry-out for adds and borrow for subtracts.
                w_c         = w_sum[DATA_WIDTH];
                w_v         = w_sub ? ((r_ar[c_msb] != w_op2[c_msb]) && (w_res[c_msb] != r_ar[c_msb]))
                                    : ((r_ar[c_msb] == w_op2[c_msb]) && (w_res[c_msb] != r_ar[c_msb]));
                w_wr_ar     = (IR[5:3] <= 3'b011);
                w_wr_flags  = (IR[5:3] <= 3'b100);
                w_start_mul = (IR[5:3] == 3'b101);
            end
            2'b10: begin
                w_wr_ar    = 1'b1;
                w_wr_flags = 1'b1;
                case (IR[5:3])
                    3'b000: w_res = r_ar & w_op2;
                    3'b001: w_res = r_ar | w_op2;
                    3'b010: w_res = r_ar ^ w_op2;
                    3'b011: w_res = ~r_ar;
                    3'b100: begin w_res = {r_ar[c_msb-1:0], 1'b0};        w_c = r_ar[c_msb]; end
                    3'b101: begin w_res = {1'b0, r_ar[c_msb:1]};          w_c = r_ar[0];     end
                    3'b110: begin w_res = {r_ar[c_msb-1:0], r_ar[c_msb]}; w_c = r_ar[c_msb]; end
                    default: begin w_res = {r_ar[0], r_ar[c_msb:1]};      w_c = r_ar[0];     end
                endcase
            end
            default: ;
        endcase

        if (w_wr_flags) begin
            w_flags[c_flag_ov]    = w_v;
            w_flags[c_flag_neg]   = w_res[c_msb];
            w_flags[c_flag_carry] = w_c;
            w_flags[c_flag_zero]  = (w_res == '0);
        end
    end

    // One shift-add step per cycle; the final step's sum is the full product.
    always_comb begin
        w_acc_nxt   = r_acc + (r_mplier[0] ? r_mcand : '0);
        w_mul_last  = (r_cnt == c_cnt_last);
        w_prod_lo   = w_acc_nxt[DATA_WIDTH-1:0];
        w_prod_hi   = w_acc_nxt[2*DATA_WIDTH-1:DATA_WIDTH];
        w_mul_flags = '0;
        w_mul_flags[c_flag_ov]    = (w_prod_hi != '0);
        w_mul_flags[c_flag_neg]   = w_prod_lo[c_msb];
        w_mul_flags[c_flag_carry] = (w_prod_hi != '0);
        w_mul_flags[c_flag_zero]  = (w_acc_nxt == '0);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_exec && w_start_mul) w_state_nxt = c_st_mul;
            default:   if (w_mul_last)            w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) r_state <= c_st_idle;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            r_ar     <= '0;
            r_hr     <= '0;
            r_flags  <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == c_st_idle) begin
            if (w_exec) begin
                if (w_wr_ar)    r_ar    <= w_res;
                if (w_wr_flags) r_flags <= w_flags;
                if (w_start_mul) begin
                    r_mcand  <= {{DATA_WIDTH{1'b0}}, r_ar};
                    r_mplier <= w_op2;
                    r_acc    <= '0;
                    r_cnt    <= '0;
                end
            end
        end else begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + c_cnt_w'(1);
            if (w_mul_last) begin
                r_ar    <= w_prod_lo;
                r_hr    <= w_prod_hi;
                r_flags <= w_mul_flags;
            end
        end
    end

    assign AR    = r_ar;
    assign HR    = r_hr;
    assign Flags = r_flags;
    assign busy  = (r_state == c_st_mul);

endmodule
`default_nettype wire

// File: tb/tb_alu_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_accumulator
//  Description : Self-checking bench for alu_accumulator (DATA_WIDTH = 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_accumulator;

    logic       clk = 1'b0;
    logic       arst;
    logic       Exec;
    logic [7:0] IR;
    logic [7:0] IBR;
    logic [7:0] MBR;
    logic [7:0] AR;
    logic [7:0] HR;
    logic [3:0] Flags;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_ar = 8'h00;
    logic [7:0] m_hr = 8'h00;
    logic [3:0] m_fl = 4'h0;

    alu_accumulator #(.DATA_WIDTH(8)) dut (
        .clk(clk), .arst(arst), .Exec(Exec), .IR(IR), .IBR(IBR), .MBR(MBR),
        .AR(AR), .HR(HR), .Flags(Flags), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: integer arithmetic on the instruction's meaning.
    task automatic model_exec(input logic [7:0] ir, input logic [7:0] ibr, input logic [7:0] mbr,
                              output bit is_mul);
        int a, b, cin, ci, r, sa, sb, sr, prod;
        logic [2:0] op;
        logic [7:0] res;
        bit c, upd, wr;
        is_mul = 1'b0;
        a   = int'(m_ar);
        b   = ir[2] ? int'(mbr) : int'(ibr);
        cin = int'(m_fl[1]);
        sa  = (a > 127) ? a - 256 : a;
        sb  = (b > 127) ? b - 256 : b;
        op  = ir[5:3];
        upd = 1'b0; wr = 1'b1; c = 1'b0; r = 0; sr = 0; ci = 0;
        if (ir == 8'h00) m_ar = ibr;
        else if (ir == 8'h04) m_ar = mbr;
        else if (ir[7:6] == 2'b01) begin
            if (op == 3'd0 || op == 3'd2) begin
                ci = (op == 3'd2) ? cin : 0;
                r = a + b + ci; sr = sa + sb + ci; c = (r > 255); upd = 1'b1;
            end else if (op == 3'd1 || op == 3'd3 || op == 3'd4) begin
                ci = (op == 3'd3) ? cin : 0;
                r = a - b - ci; sr = sa - sb - ci; c = (r < 0); upd = 1'b1; wr = (op != 3'd4);
            end else if (op == 3'd5) begin
                prod = a * b;
                m_ar = 8'(prod);
                m_hr = 8'(prod / 256);
                m_fl = {(prod > 255), m_ar[7], (prod > 255), (prod == 0)};
                is_mul = 1'b1;
            end
        end else if (ir[7:6] == 2'b10) begin
            upd = 1'b1;
            case (op)
                3'd0: r = a & b;
                3'd1: r = a | b;
                3'd2: r = a ^ b;
                3'd3: r = 255 - a;
                3'd4: begin r = (a * 2) % 256;             c = (a >= 128); end
                3'd5: begin r = a / 2;                     c = (a % 2 == 1); end
                3'd6: begin r = (a * 2) % 256 + a / 128;   c = (a >= 128); end
                default: begin r = a / 2 + (a % 2) * 128;  c = (a % 2 == 1); end
            endcase
        end
        if (upd) begin
            res = 8'(r);
            if (wr) m_ar = res;
            m_fl = {(sr > 127 || sr < -128), res[7], c, (res == 8'h00)};
        end
    endtask

    task automatic strobe(input logic [7:0] ir, input logic [7:0] ibr, input logic [7:0] mbr,
                          output bit is_mul);
        @(negedge clk);
        model_exec(ir, ibr, mbr, is_mul);
        Exec = 1'b1; IR = ir; IBR = ibr; MBR = mbr;
        @(negedge clk);
        Exec = 1'b0;
    endtask

    task automatic test_reset();
        bit m;
        arst = 1'b1; Exec = 1'b0; IR = 8'h00; IBR = 8'h00; MBR = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if ({AR, HR, Flags, busy} !== 21'h0) begin
            errors++;
            $display("FAIL reset_initial: got AR=%h HR=%h F=%b busy=%b, want all zero", AR, HR, Flags, busy);
        end
        arst = 1'b0;
        strobe(8'h00, 8'h12, 8'h00, m);
        strobe(8'h68, 8'h34, 8'h00, m);
        repeat (3) @(negedge clk);
        arst = 1'b1;
        repeat (2) @(negedge clk);
        arst = 1'b0;
        m_ar = 8'h00; m_hr = 8'h00; m_fl = 4'h0;
        checks++;
        if ({AR, HR, Flags, busy} !== 21'h0) begin
            errors++;
            $display("FAIL reset_mid_mul: got AR=%h HR=%h F=%b busy=%b, want all zero", AR, HR, Flags, busy);
        end
        strobe(8'h00, 8'h3C, 8'h00, m);
        checks++;
        if ({AR, busy} !== {8'h3C, 1'b0}) begin
            errors++;
            $display("FAIL reset_then_load: got AR=%h busy=%b, want 3c/0", AR, busy);
        end
    endtask

    task automatic test_add_imm();
        bit m;
        strobe(8'h00, 8'h7F, 8'h00, m);
        strobe(8'h40, 8'h01, 8'h00, m);
        checks++;
        if ({AR, Flags} !== {8'h80, 4'b1100}) begin
            errors++;
            $display("FAIL add_imm: got AR=%h F=%b, want 80/1100", AR, Flags);
        end
    endtask

    task automatic test_sub_cmp_mem();
        bit m;
        strobe(8'h00, 8'h10, 8'h00, m);
        strobe(8'h4C, 8'hAA, 8'h20, m);
        checks++;
        if ({AR, Flags} !== {8'hF0, 4'b0110}) begin
            errors++;
            $display("FAIL sub_mem: got AR=%h F=%b, want f0/0110", AR, Flags);
        end
        strobe(8'h64, 8'h00, 8'hF0, m);
        checks++;
        if ({AR, Flags} !== {8'hF0, 4'b0001}) begin
            errors++;
            $display("FAIL cmp_mem: got AR=%h F=%b, want f0/0001", AR, Flags);
        end
    endtask

    task automatic test_mul();
        bit m;
        int n;
        strobe(8'h00, 8'hFF, 8'h00, m);
        strobe(8'h68, 8'hFF, 8'h00, m);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (n == 3) begin Exec = 1'b1; IR = 8'h00; IBR = 8'h55; end
            else Exec = 1'b0;
            if (n == 5) begin
                checks++;
                if ({AR, HR} !== {8'hFF, 8'h00}) begin
                    errors++;
                    $display("FAIL mul_hold: got AR=%h HR=%h mid-MUL, want ff/00", AR, HR);
                end
            end
            @(negedge clk);
        end
        Exec = 1'b0;
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL mul_busy_len: got %0d busy cycles, want 8", n);
        end
        checks++;
        if ({AR, HR, Flags, busy} !== {8'h01, 8'hFE, 4'b1010, 1'b0}) begin
            errors++;
            $display("FAIL mul_result: got AR=%h HR=%h F=%b busy=%b, want 01/fe/1010/0", AR, HR, Flags, busy);
        end
    endtask

    task automatic test_shift_rotate();
        bit m;
        strobe(8'h00, 8'h81, 8'h00, m);
        strobe(8'hA0, 8'h00, 8'h00, m);
        checks++;
        if ({AR, Flags} !== {8'h02, 4'b0010}) begin
            errors++;
            $display("FAIL shl: got AR=%h F=%b, want 02/0010", AR, Flags);
        end
        strobe(8'h00, 8'h81, 8'h00, m);
        strobe(8'hB8, 8'h00, 8'h00, m);
        checks++;
        if ({AR, Flags} !== {8'hC0, 4'b0110}) begin
            errors++;
            $display("FAIL ror: got AR=%h F=%b, want c0/0110", AR, Flags);
        end
        strobe(8'h00, 8'h01, 8'h00, m);
        strobe(8'hA8, 8'h00, 8'h00, m);
        checks++;
        if ({AR, Flags} !== {8'h00, 4'b0011}) begin
            errors++;
            $display("FAIL shr: got AR=%h F=%b, want 00/0011", AR, Flags);
        end
    endtask

    task automatic test_back_to_back();
        bit m;
        @(negedge clk);
        model_exec(8'h00, 8'hFF, 8'h00, m);
        Exec = 1'b1; IR = 8'h00; IBR = 8'hFF;
        @(negedge clk);
        checks++;
        if (AR !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_load: got AR=%h, want ff", AR);
        end
        model_exec(8'h40, 8'h01, 8'h00, m);
        IR = 8'h40; IBR = 8'h01;
        @(negedge clk);
        checks++;
        if ({AR, Flags} !== {8'h00, 4'b0011}) begin
            errors++;
            $display("FAIL b2b_add: got AR=%h F=%b, want 00/0011", AR, Flags);
        end
        model_exec(8'h50, 8'h00, 8'h00, m);
        IR = 8'h50; IBR = 8'h00;
        @(negedge clk);
        Exec = 1'b0;
        checks++;
        if ({AR, Flags} !== {8'h01, 4'b0000}) begin
            errors++;
            $display("FAIL b2b_adc: got AR=%h F=%b, want 01/0000", AR, Flags);
        end
    endtask

    task automatic test_random();
        bit m;
        int n;
        logic [7:0] ir, ibr, mbr;
        for (int i = 0; i < 60; i++) begin
            ir  = 8'($urandom);
            ibr = 8'($urandom);
            mbr = 8'($urandom);
            strobe(ir, ibr, mbr, m);
            if (m) begin
                n = 0;
                while (busy === 1'b1 && n < 40) begin n++; @(negedge clk); end
            end
            checks++;
            if ({AR, HR, Flags, busy} !== {m_ar, m_hr, m_fl, 1'b0}) begin
                errors++;
                $display("FAIL random[%0d] IR=%h IBR=%h MBR=%h: got AR=%h HR=%h F=%b busy=%b, want %h/%h/%b/0",
                         i, ir, ibr, mbr, AR, HR, Flags, busy, m_ar, m_hr, m_fl);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_imm();
        test_sub_cmp_mem();
        test_mul();
        test_shift_rotate();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
